// File: rtl/fir_delay_gen.sv
// FIR timing generator: start-up counter, window strobe and a
// pipeline-aligned copy of the window strobe for the DSP58 accumulator.
//
// Parameters:
//   delay1        - cycles from filter_delay to dsp58_delay (1..63)
//   filter_length - taps per output window (power of two, >= 2)
// Ports:
//   clk            - system clock, rising edge
//   rst_n          - synchronous reset, active HIGH (1 = reset)
//   starting_delay - cycles since reset release, saturating at 63
//   filter_delay   - one-cycle strobe on the last tap of each window
//   dsp58_delay    - filter_delay delayed by delay1 cycles (registered)

module fir_delay_gen #(
  parameter int delay1        = 4,
  parameter int filter_length = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [5:0] starting_delay,
  output logic       filter_delay,
  output logic       dsp58_delay
);

  localparam int PW = $clog2(filter_length);
  localparam logic [PW-1:0] LAST = PW'(filter_length - 1);

  // Initialisers give the same state at configuration as after reset.
  logic [5:0]        sd_q = '0;
  logic [5:0]        sd_d;
  logic [PW-1:0]     ph_q = '0;
  logic [PW-1:0]     ph_d;
  logic [delay1-1:0] sr_q = '0;
  logic [delay1-1:0] sr_d;
  logic              started;
  logic              win;

  // Addressing is live once the start-up counter has left zero.
  assign started = (sd_q != 6'd0);
  assign win     = started && (ph_q == LAST);

  always_comb begin
    sd_d = sd_q;
    if (sd_q != 6'd63) begin
      sd_d = sd_q + 6'd1;
    end
  end

  // Power-of-two window: natural wrap of the counter is the reload.
  always_comb begin
    ph_d = ph_q;
    if (started) begin
      ph_d = ph_q + PW'(1);
    end
  end

  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = win;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      sd_q <= '0;
      ph_q <= '0;
      sr_q <= '0;
    end else begin
      sd_q <= sd_d;
      ph_q <= ph_d;
      sr_q <= sr_d;
    end
  end

  assign starting_delay = sd_q;
  assign filter_delay   = win;
  assign dsp58_delay    = sr_q[delay1-1];

endmodule

// File: tb/tb_fir_delay_gen.sv
// Self-checking bench for fir_delay_gen: default instance (L=16, D=4)
// and a coincident-strobe instance (L=8, D=8), random reset pulses.

module tb_fir_delay_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] sd0, sd1;
  logic       fd0, fd1, ds0, ds1;
  int         checks = 0;
  int         errors = 0;
  int         m = 0;

  always #5 clk = ~clk;

  fir_delay_gen #(.delay1(4), .filter_length(16)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .starting_delay(sd0), .filter_delay(fd0), .dsp58_delay(ds0)
  );

  fir_delay_gen #(.delay1(8), .filter_length(8)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .starting_delay(sd1), .filter_delay(fd1), .dsp58_delay(ds1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0d want=%0d", nm, m, act, exp);
    end
  endtask

  // Model: m = rising edges since reset release (0 while in reset).
  function automatic int e_sd(int k);
    return (k > 63) ? 63 : k;
  endfunction

  function automatic int e_fd(int k, int l);
    return (k >= 1 && k % l == 0) ? 1 : 0;
  endfunction

  function automatic int e_ds(int k, int l, int d);
    return e_fd(k - d, l);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst_n) m = 0;
      else m = m + 1;
      @(negedge clk);
      chk("sd0", int'(sd0), e_sd(m));
      chk("fd0", int'(fd0), e_fd(m, 16));
      chk("ds0", int'(ds0), e_ds(m, 16, 4));
      chk("sd1", int'(sd1), e_sd(m));
      chk("fd1", int'(fd1), e_fd(m, 8));
      chk("ds1", int'(ds1), e_ds(m, 8, 8));
      // Hand-derived pins on the model itself.
      if (m == 1)  chk("pin_sd_e1", int'(sd0), 1);
      if (m == 15) chk("pin_fd_e15", int'(fd0), 0);
      if (m == 16) chk("pin_fd_e16", int'(fd0), 1);
      if (m == 19) chk("pin_ds_e19", int'(ds0), 0);
      if (m == 20) chk("pin_ds_e20", int'(ds0), 1);
      if (m == 16) chk("pin_co_e16", int'({fd1, ds1}), 3);
      if (m == 8)  chk("pin_co_e8", int'({fd1, ds1}), 2);
      if (m == 70) chk("pin_sat_e70", int'(sd0), 63);
    end
  end

  task automatic hold(input logic r, input int n);
    rst_n = r;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    hold(1'b1, 5);
    hold(1'b0, 25);
    hold(1'b1, 1);
    hold(1'b0, 100);
    for (int i = 0; i < 8; i++) begin
      hold(1'b1, 1 + int'($urandom_range(2)));
      hold(1'b0, 1 + int'($urandom_range(80)));
    end
    hold(1'b1, 2);
    hold(1'b0, 90);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
